// File: rtl/aes_pkg.sv
// aes_pkg
// Shared types and sizing for the SubBytes/SubWord scheduler.
//   sched_state_t : scheduler FSM states (IDLE, BUSY, DRAIN, DONE)
//   slot_src_t    : owner of an S-box issue slot (state column or key word)
//   slot_tag_t    : tag that travels one cycle behind each issue
//   NUM_COLS      : columns per 128-bit state
//   LANE_W        : width of one S-box bank issue (one column / one word)
package aes_pkg;

  localparam int NUM_COLS  = 4;
  localparam int LANE_W    = 32;
  localparam int COL_IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN,
    DONE
  } sched_state_t;

  typedef enum logic {
    SRC_STATE,
    SRC_KW
  } slot_src_t;

  typedef struct packed {
    logic                 valid;
    slot_src_t            src;
    logic [COL_IDX_W-1:0] col;
  } slot_tag_t;

endpackage

// File: rtl/sbox_bank.sv
// sbox_bank
// Four AES forward S-boxes side by side with a registered output, so one
// 32-bit word is substituted per cycle with one cycle of latency.
// Ports:
//   clk       in   clock
//   lane_word in   32-bit word to substitute (4 bytes)
//   sub_word  out  byte-wise S-box of lane_word, valid one cycle later
module sbox_bank
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic [LANE_W-1:0] lane_word,
  output logic [LANE_W-1:0] sub_word
);

  localparam int NUM_LANES = LANE_W / 8;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Datapath only: no reset, the scheduler's tag register decides whether
  // the registered output means anything.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      sub_word[8*i +: 8] <= SBOX[lane_word[8*i +: 8]];
    end
  end

endmodule

// File: rtl/sub_bytes_scheduler.sv
// sub_bytes_scheduler
// Time-shares one 4-lane S-box bank between a 128-bit SubBytes job (one
// column per slot) and single-word SubWord requests from key expansion.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   st_valid/st_ready       state input handshake, st_data 128-bit state
//                           (column c = st_data[127-32c -: 32])
//   st_out_valid/_ready     result handshake, st_out_data = SubBytes(state)
//   kw_req (level)          key-word request, kw_word sampled in grant cycle
//   kw_gnt (pulse)          grant, same cycle the word is sampled
//   kw_done (pulse)         one cycle after the grant, kw_result valid then
module sub_bytes_scheduler
  import aes_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [NUM_COLS*LANE_W-1:0] st_data,
  output logic                       st_out_valid,
  input  logic                       st_out_ready,
  output logic [NUM_COLS*LANE_W-1:0] st_out_data,
  input  logic                       kw_req,
  input  logic [LANE_W-1:0]          kw_word,
  output logic                       kw_gnt,
  output logic                       kw_done,
  output logic [LANE_W-1:0]          kw_result
);

  localparam int STATE_W = NUM_COLS * LANE_W;

  sched_state_t         state;
  sched_state_t         state_next;
  logic [COL_IDX_W-1:0] col_cnt;
  logic [STATE_W-1:0]   st_buf;
  logic                 last_kw;
  slot_tag_t            tag;
  logic                 col_pending;
  logic                 issue_col;
  logic                 accept;
  logic [LANE_W-1:0]    bank_in;
  logic [LANE_W-1:0]    bank_out;

  // A state column is waiting for a slot only while BUSY; DRAIN/DONE/IDLE
  // leave every slot free for key words.
  assign col_pending = (state == BUSY);

  // Key word wins unless it also won the previous slot while a column waits,
  // which gives strict alternation under contention. Gating with rst_n keeps
  // a word from being granted in a cycle whose edge discards it.
  assign kw_gnt    = rst_n && kw_req && (!col_pending || !last_kw);
  assign issue_col = col_pending && !kw_gnt;

  assign st_ready     = rst_n && (state == IDLE);
  assign accept       = st_valid && st_ready;
  assign st_out_valid = (state == DONE);

  // A grant made just before reset must not report completion while
  // reset is being applied.
  assign kw_done   = rst_n && tag.valid && (tag.src == SRC_KW);
  assign kw_result = kw_done ? bank_out : '0;

  assign bank_in = kw_gnt ? kw_word
                          : st_buf[STATE_W-1-LANE_W*int'(col_cnt) -: LANE_W];

  sbox_bank u_sbox_bank (
    .clk       (clk),
    .lane_word (bank_in),
    .sub_word  (bank_out)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (issue_col && (col_cnt == COL_IDX_W'(NUM_COLS-1))) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    if (st_out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The tag follows each issue by one cycle so the bank output is routed to
  // the right destination when it appears.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      col_cnt     <= '0;
      st_buf      <= '0;
      last_kw     <= 1'b0;
      tag         <= '0;
      st_out_data <= '0;
    end else begin
      state   <= state_next;
      last_kw <= kw_gnt;
      if (accept) begin
        st_buf  <= st_data;
        col_cnt <= '0;
      end else if (issue_col) begin
        col_cnt <= col_cnt + 1'b1;
      end
      tag.valid <= kw_gnt || issue_col;
      tag.src   <= kw_gnt ? SRC_KW : SRC_STATE;
      tag.col   <= col_cnt;
      if (tag.valid && (tag.src == SRC_STATE)) begin
        st_out_data[STATE_W-1-LANE_W*int'(tag.col) -: LANE_W] <= bank_out;
      end
    end
  end

endmodule

// File: tb/tb_sub_bytes_scheduler.sv
// tb_sub_bytes_scheduler
// Directed checks of the SubBytes/SubWord scheduler against hand-computed
// FIPS-197 S-box values. Inputs change 1 time unit after the rising edge,
// outputs are sampled on the falling edge.
module tb_sub_bytes_scheduler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         st_valid;
  logic         st_ready;
  logic [127:0] st_data;
  logic         st_out_valid;
  logic         st_out_ready;
  logic [127:0] st_out_data;
  logic         kw_req;
  logic [31:0]  kw_word;
  logic         kw_gnt;
  logic         kw_done;
  logic [31:0]  kw_result;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] VEC1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] EXP1 = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [127:0] VEC2 = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] EXP2 = 128'hd42711aee0bf98f1b8b45de51e415230;

  sub_bytes_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_data      (st_data),
    .st_out_valid (st_out_valid),
    .st_out_ready (st_out_ready),
    .st_out_data  (st_out_data),
    .kw_req       (kw_req),
    .kw_word      (kw_word),
    .kw_gnt       (kw_gnt),
    .kw_done      (kw_done),
    .kw_result    (kw_result)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; st_valid = 1'b0; st_data = '0; st_out_ready = 1'b0;
    kw_req = 1'b1; kw_word = 32'hcf4f3c09;
    next_cycle();
    next_cycle();
    mid_cycle();
    total++;
    if (st_out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", st_out_valid); end
    total++;
    if (kw_gnt !== 1'b0) begin bad++; $display("[TB] FAIL reset_kw_gnt: got %b want 0", kw_gnt); end
    total++;
    if (kw_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_kw_done: got %b want 0", kw_done); end
    total++;
    if (st_out_data !== 128'h0) begin bad++; $display("[TB] FAIL reset_out_data: got %h want 0", st_out_data); end
    total++;
    if (kw_result !== 32'h0) begin bad++; $display("[TB] FAIL reset_kw_result: got %h want 0", kw_result); end
    next_cycle();
    rst_n = 1'b1; kw_req = 1'b0;
    mid_cycle();
    total++;
    if (st_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_release_ready: got %b want 1", st_ready); end
  endtask

  task automatic test_state_basic();
    int rise;
    next_cycle();
    st_valid = 1'b1; st_data = VEC1; st_out_ready = 1'b1;
    mid_cycle();
    total++;
    if (st_ready !== 1'b1) begin bad++; $display("[TB] FAIL basic_accept_ready: got %b want 1", st_ready); end
    next_cycle();
    st_valid = 1'b0; st_data = '0;
    rise = 0;
    for (int k = 1; k <= 12 && rise == 0; k++) begin
      mid_cycle();
      if (k == 1) begin
        total++;
        if (st_ready !== 1'b0) begin bad++; $display("[TB] FAIL basic_busy_ready: got %b want 0", st_ready); end
      end
      if (st_out_valid === 1'b1) rise = k;
      else next_cycle();
    end
    total++;
    if (rise != 6) begin bad++; $display("[TB] FAIL basic_latency: got %0d want 6", rise); end
    total++;
    if (st_out_data !== EXP1) begin bad++; $display("[TB] FAIL basic_data: got %h want %h", st_out_data, EXP1); end
    next_cycle();
    mid_cycle();
    total++;
    if (st_ready !== 1'b1 || st_out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL basic_return_idle: got ready=%b valid=%b want ready=1 valid=0", st_ready, st_out_valid);
    end
  endtask

  task automatic test_kw_idle();
    next_cycle();
    kw_req = 1'b1; kw_word = 32'hcf4f3c09;
    mid_cycle();
    total++;
    if (kw_gnt !== 1'b1 || kw_done !== 1'b0) begin
      bad++; $display("[TB] FAIL kw_idle_grant: got gnt=%b done=%b want gnt=1 done=0", kw_gnt, kw_done);
    end
    next_cycle();
    kw_word = 32'h00010203;
    mid_cycle();
    total++;
    if (kw_gnt !== 1'b1) begin bad++; $display("[TB] FAIL kw_b2b_grant1: got %b want 1", kw_gnt); end
    total++;
    if (kw_done !== 1'b1 || kw_result !== 32'h8a84eb01) begin
      bad++; $display("[TB] FAIL kw_idle_result: got done=%b res=%h want done=1 res=8a84eb01", kw_done, kw_result);
    end
    next_cycle();
    kw_word = 32'h0c0d0e0f;
    mid_cycle();
    total++;
    if (kw_gnt !== 1'b1 || kw_done !== 1'b1 || kw_result !== 32'h637c777b) begin
      bad++; $display("[TB] FAIL kw_b2b_result1: got gnt=%b done=%b res=%h want 1 1 637c777b", kw_gnt, kw_done, kw_result);
    end
    next_cycle();
    kw_req = 1'b0;
    mid_cycle();
    total++;
    if (kw_gnt !== 1'b0 || kw_done !== 1'b1 || kw_result !== 32'hfed7ab76) begin
      bad++; $display("[TB] FAIL kw_b2b_result2: got gnt=%b done=%b res=%h want 0 1 fed7ab76", kw_gnt, kw_done, kw_result);
    end
    next_cycle();
    mid_cycle();
    total++;
    if (kw_done !== 1'b0 || kw_result !== 32'h0) begin
      bad++; $display("[TB] FAIL kw_done_pulse: got done=%b res=%h want 0 0", kw_done, kw_result);
    end
  endtask

  task automatic test_contention();
    logic [31:0] words   [3] = '{32'h00010203, 32'h10203040, 32'h2b7e1516};
    logic [31:0] results [3] = '{32'h637c777b, 32'hcab70409, 32'hf1f35947};
    int   grants;
    logic exp_g;
    logic prev_g;
    next_cycle();
    st_valid = 1'b1; st_data = VEC1; st_out_ready = 1'b1;
    mid_cycle();
    total++;
    if (st_ready !== 1'b1) begin bad++; $display("[TB] FAIL cont_accept_ready: got %b want 1", st_ready); end
    next_cycle();
    st_valid = 1'b0; st_data = '0;
    next_cycle();
    kw_req = 1'b1; kw_word = words[0];
    grants = 0;
    prev_g = 1'b0;
    for (int k = 2; k <= 9; k++) begin
      mid_cycle();
      exp_g = (k == 2 || k == 4 || k == 6);
      total++;
      if (kw_gnt !== exp_g) begin bad++; $display("[TB] FAIL cont_gnt_T%0d: got %b want %b", k, kw_gnt, exp_g); end
      total++;
      if (kw_done !== prev_g) begin bad++; $display("[TB] FAIL cont_done_T%0d: got %b want %b", k, kw_done, prev_g); end
      if (prev_g) begin
        total++;
        if (kw_result !== results[grants-1]) begin
          bad++; $display("[TB] FAIL cont_result_T%0d: got %h want %h", k, kw_result, results[grants-1]);
        end
      end
      total++;
      if (st_out_valid !== (k == 9)) begin
        bad++; $display("[TB] FAIL cont_out_valid_T%0d: got %b want %b", k, st_out_valid, (k == 9));
      end
      if (k == 9) begin
        total++;
        if (st_out_data !== EXP1) begin bad++; $display("[TB] FAIL cont_data: got %h want %h", st_out_data, EXP1); end
      end
      if (exp_g) grants++;
      prev_g = exp_g;
      next_cycle();
      if (grants == 3) kw_req = 1'b0;
      else kw_word = words[grants];
    end
    mid_cycle();
    total++;
    if (st_ready !== 1'b1) begin bad++; $display("[TB] FAIL cont_return_idle: got %b want 1", st_ready); end
  endtask

  task automatic test_stall();
    int rise;
    next_cycle();
    st_valid = 1'b1; st_data = VEC2; st_out_ready = 1'b0;
    next_cycle();
    st_valid = 1'b0; st_data = '0;
    rise = 0;
    for (int k = 1; k <= 12 && rise == 0; k++) begin
      mid_cycle();
      if (st_out_valid === 1'b1) rise = k;
      else next_cycle();
    end
    total++;
    if (rise != 6) begin bad++; $display("[TB] FAIL stall_latency: got %0d want 6", rise); end
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      st_valid = 1'b1; st_data = VEC1;
      kw_req = (i == 3); kw_word = 32'hf0e0d0c0;
      mid_cycle();
      total++;
      if (st_ready !== 1'b0 || st_out_valid !== 1'b1 || st_out_data !== EXP2) begin
        bad++;
        $display("[TB] FAIL stall_hold_%0d: got ready=%b valid=%b data=%h want 0 1 %h", i, st_ready, st_out_valid, st_out_data, EXP2);
      end
      if (i == 3) begin
        total++;
        if (kw_gnt !== 1'b1) begin bad++; $display("[TB] FAIL stall_kw_gnt: got %b want 1", kw_gnt); end
      end
      if (i == 4) begin
        total++;
        if (kw_done !== 1'b1 || kw_result !== 32'h8ce170ba) begin
          bad++; $display("[TB] FAIL stall_kw_result: got done=%b res=%h want 1 8ce170ba", kw_done, kw_result);
        end
      end
    end
    next_cycle();
    st_out_ready = 1'b1; kw_req = 1'b0;
    mid_cycle();
    total++;
    if (st_ready !== 1'b0 || st_out_valid !== 1'b1) begin
      bad++; $display("[TB] FAIL stall_release: got ready=%b valid=%b want 0 1", st_ready, st_out_valid);
    end
    next_cycle();
    mid_cycle();
    total++;
    if (st_ready !== 1'b1) begin bad++; $display("[TB] FAIL stall_next_accept: got %b want 1", st_ready); end
    next_cycle();
    st_valid = 1'b0; st_data = '0;
    rise = 0;
    for (int k = 1; k <= 12 && rise == 0; k++) begin
      mid_cycle();
      if (st_out_valid === 1'b1) rise = k;
      else next_cycle();
    end
    total++;
    if (rise != 6) begin bad++; $display("[TB] FAIL stall_next_latency: got %0d want 6", rise); end
    total++;
    if (st_out_data !== EXP1) begin bad++; $display("[TB] FAIL stall_next_data: got %h want %h", st_out_data, EXP1); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    logic seen;
    next_cycle();
    st_valid = 1'b1; st_data = VEC1; st_out_ready = 1'b1;
    next_cycle();
    st_valid = 1'b0; st_data = '0;
    next_cycle();
    next_cycle();
    kw_req = 1'b1; kw_word = 32'h09cf4f3c;
    mid_cycle();
    total++;
    if (kw_gnt !== 1'b1) begin bad++; $display("[TB] FAIL rmid_kw_gnt: got %b want 1", kw_gnt); end
    next_cycle();
    rst_n = 1'b0; kw_word = 32'h2b7e1516;
    mid_cycle();
    total++;
    if (kw_done !== 1'b0 || kw_gnt !== 1'b0 || st_out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL rmid_in_reset: got done=%b gnt=%b valid=%b want 0 0 0", kw_done, kw_gnt, st_out_valid);
    end
    next_cycle();
    kw_req = 1'b0;
    mid_cycle();
    total++;
    if (st_out_valid !== 1'b0 || kw_done !== 1'b0 || st_out_data !== 128'h0 || kw_result !== 32'h0) begin
      bad++;
      $display("[TB] FAIL rmid_cleared: got valid=%b done=%b data=%h res=%h want all 0", st_out_valid, kw_done, st_out_data, kw_result);
    end
    next_cycle();
    rst_n = 1'b1;
    mid_cycle();
    total++;
    if (st_ready !== 1'b1) begin bad++; $display("[TB] FAIL rmid_ready_after: got %b want 1", st_ready); end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      mid_cycle();
      if (st_out_valid !== 1'b0 || kw_done !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("[TB] FAIL rmid_stale_work: got %b want 0", seen); end
    next_cycle();
    kw_req = 1'b1; kw_word = 32'h09cf4f3c;
    next_cycle();
    kw_req = 1'b0;
    mid_cycle();
    total++;
    if (kw_done !== 1'b1 || kw_result !== 32'h018a84eb) begin
      bad++; $display("[TB] FAIL rmid_kw_after: got done=%b res=%h want 1 018a84eb", kw_done, kw_result);
    end
  endtask

  initial begin
    test_reset();
    test_state_basic();
    test_kw_idle();
    test_contention();
    test_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sub_bytes_scheduler.md
SUB_BYTES_SCHEDULER -- requirements
Module: sub_bytes_scheduler

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have state input ports: st_valid in 1; st_ready out 1; st_data in 128, column c = st_data[127-32c -: 32], byte order MSB-first.
REQ-004 SHALL have state output ports: st_out_valid out 1; st_out_ready in 1; st_out_data out 128, SubBytes of accepted st_data, same byte order.
REQ-005 SHALL have key-word ports: kw_req in 1 (level); kw_word in 32; kw_gnt out 1 (pulse); kw_done out 1 (pulse); kw_result out 32, SubWord(kw_word).

Function
REQ-006 SHALL share one 4-lane S-box bank (32 bits/cycle, 1-cycle registered latency) between state SubBytes and key-expansion SubWord.
REQ-007 SHALL use FSM states IDLE, BUSY, DRAIN, DONE.
REQ-008 IDLE: st_ready=1; st_valid&&st_ready latches st_data, clears column counter, goes to BUSY; st_ready=0 in all other states.
REQ-009 BUSY: each cycle is one issue slot, given to the state job (next column, counter 0..3) or to kw; after column 3 issues, go to DRAIN.
REQ-010 DRAIN: capture column 3 result, go to DONE; st_out_valid=1 from the following cycle.
REQ-011 DONE: hold st_out_valid and st_out_data stable until st_out_ready=1; handshake cycle returns to IDLE.
REQ-012 Column result SHALL be captured into st_out_data at the end of the cycle after its issue, tracked by a tag register (valid, source, column index).
REQ-013 Arbitration per slot: kw_req granted if no state column is pending, or if the previous slot was not a kw grant; otherwise the state column wins (strict alternation under contention, no starvation).
REQ-014 Uncontended latency: acceptance in cycle T, columns issue T+1..T+4, st_out_valid=1 in T+6.
REQ-015 kw slots SHALL be granted in any state, including IDLE, DRAIN and DONE; back-to-back kw grants are allowed when no state column is pending.
REQ-016 kw_gnt=1 in grant cycle G, with kw_word sampled in G; kw_done=1 and kw_result valid in G+1 only.
REQ-017 Requester SHALL treat kw_req high in G+1 as a new request; the block SHALL never grant one kw_word sample twice.
REQ-018 Contention in a kw slot delays the state job by exactly one cycle per kw grant; st_out_data is unaffected.
REQ-019 st_valid outside IDLE is ignored; st_data is not sampled.
REQ-020 st_out_ready low in DONE SHALL stall indefinitely without loss; kw service continues.

Reset
REQ-021 rst_n=0 at a clock edge: FSM to IDLE, counter=0, tag invalid, st_out_valid=0, kw_gnt=0, kw_done=0, st_out_data=0, kw_result=0.
REQ-022 Reset mid-operation SHALL drop all in-flight work; no kw_done follows a grant made in the cycle before reset; st_ready=1 in the first cycle after rst_n rises.

Structure
REQ-023 Package aes_pkg SHALL hold the FSM state enum, NUM_COLS=4, LANE_W=32.
REQ-024 SHALL instantiate one sub-module, sbox_bank: four registered S-boxes, 32-bit in, 32-bit out, clk only.
REQ-025 Target size: 120-400 RTL lines excluding sbox_bank.

Verification
REQ-026 st_data=00112233445566778899aabbccddeeff accepted at T, no kw -> st_out_data=638293c31bfc33f5c4eeacea4bc12816, st_out_valid rises at T+6.
REQ-027 IDLE, kw_req=1, kw_word=cf4f3c09 -> kw_gnt in the same cycle, kw_done next cycle, kw_result=8a84eb01.
REQ-028 State job per REQ-026 with kw_req held high from T+2 for 3 grants -> slots alternate state/kw, st_out_valid at T+9, st_out_data unchanged, every kw_result correct.
REQ-029 st_out_ready held 0 for 10 cycles in DONE, with st_valid=1 -> st_ready=0, output stable; release -> IDLE, new job accepted next cycle.
REQ-030 rst_n=0 during BUSY column 2 and in the cycle after a kw grant -> no st_out_valid, no kw_done, outputs per REQ-021.
REQ-031 Random st/kw traffic vs. software S-box model -> all results match, no duplicate or lost grants.
